// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: control-bundle bit positions and MEM-stage FSM states.
// Latency: n/a (types and constants only). Backpressure: n/a.
// Imported by the MEM stage and its MEM/WB register.
package mips_pkg;

    localparam int M_BRANCH    = 2;
    localparam int M_MEMREAD   = 1;
    localparam int M_MEMWRITE  = 0;
    localparam int WB_REGWRITE = 1;
    localparam int WB_MEMTOREG = 0;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } mem_state_t;

endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register with reset, load and bubble (clear WB controls, hold data).
// Latency: 1 cycle from load to outputs. Backpressure: none; holds when neither load nor bubble.
// Priority is rst > load > bubble.
module mem_wb_reg
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        bubble,
    input  logic [1:0]  wb_in,
    input  logic [31:0] read_data_in,
    input  logic [31:0] alu_in,
    input  logic [4:0]  wreg_in,
    output logic [1:0]  wb_out,
    output logic [31:0] read_data_out,
    output logic [31:0] alu_out,
    output logic [4:0]  wreg_out
);

    always_ff @(posedge clk) begin
        if (rst) begin
            wb_out        <= '0;
            read_data_out <= '0;
            alu_out       <= '0;
            wreg_out      <= '0;
        end else if (load) begin
            wb_out        <= wb_in;
            read_data_out <= read_data_in;
            alu_out       <= alu_in;
            wreg_out      <= wreg_in;
        end else if (bubble) begin
            wb_out        <= '0;
        end
    end

endmodule

// File: rtl/mem_stage.sv
// MEM stage: data-memory req/ack access, branch resolve, MEM/WB drive. Optional MEM_TIMEOUT_EN aborts stuck accesses.
// Latency: 1 cycle for ALU/branch ops, >= 2 cycles for memory ops (IDLE cycle + ack cycle).
// Backpressure: stall holds upstream from the memory-op IDLE cycle through the ack cycle.
module mem_stage
    import mips_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int AW      = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [1:0]    WB,
    input  logic [2:0]    M,
    input  logic [31:0]   PC,
    input  logic          zero,
    input  logic [31:0]   ALUresult,
    input  logic [31:0]   writeData,
    input  logic [4:0]    writeRegister,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata,
    input  logic          mem_ack,
    output logic          stall,
    output logic          PCSrc,
    output logic [31:0]   branch_target,
    output logic [1:0]    WB_output,
    output logic [31:0]   readData_output,
    output logic [31:0]   ALUresult_output,
    output logic [4:0]    writeRegister_output,
    output logic          mem_err
);

    mem_state_t state, state_nxt;
    logic       mem_op;
    logic       done;
    logic       abort;
    logic       wb_load;
    logic       wb_bubble;
    logic [31:0] rdata_sel;

    assign mem_op = M[M_MEMREAD] | M[M_MEMWRITE];

`ifdef MEM_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt;
    logic          err_q;

    assign abort   = (state == ACCESS) && !mem_ack && (cnt == CW'(TIMEOUT - 1));
    assign mem_err = err_q;
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT > 0);
    assign abort          = 1'b0;
    assign mem_err        = 1'b0;
`endif

    // done marks the cycle after completion: upstream is still frozen on the
    // retired instruction, so it must not launch a second access.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            done  <= (state == ACCESS) && (mem_ack || abort);
        end
    end

`ifdef MEM_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt   <= '0;
            err_q <= 1'b0;
        end else begin
            cnt   <= (state == ACCESS && !mem_ack) ? cnt + 1'b1 : '0;
            err_q <= abort;
        end
    end
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (mem_op && !done) state_nxt = ACCESS;
            ACCESS:  if (mem_ack || abort) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        stall     = 1'b0;
        wb_load   = 1'b0;
        rdata_sel = '0;
        case (state)
            IDLE: begin
                stall   = mem_op && !done;
                wb_load = !mem_op;
            end
            ACCESS: begin
                mem_req = 1'b1;
                mem_we  = M[M_MEMWRITE];
                stall   = 1'b1;
                wb_load = mem_ack;
                // Write wins on the illegal read+write encoding.
                if (mem_ack && M[M_MEMREAD] && !M[M_MEMWRITE])
                    rdata_sel = mem_rdata;
            end
            default: ;
        endcase
        wb_bubble = !wb_load;
    end

    assign mem_addr      = ALUresult[AW-1:0];
    assign mem_wdata     = writeData;
    assign branch_target = PC;
    assign PCSrc         = M[M_BRANCH] & zero & ~stall;

    mem_wb_reg u_mem_wb_reg (
        .clk           (clk),
        .rst           (rst),
        .load          (wb_load),
        .bubble        (wb_bubble),
        .wb_in         (WB),
        .read_data_in  (rdata_sel),
        .alu_in        (ALUresult),
        .wreg_in       (writeRegister),
        .wb_out        (WB_output),
        .read_data_out (readData_output),
        .alu_out       (ALUresult_output),
        .wreg_out      (writeRegister_output)
    );

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Reader side of the EX/MEM pipeline register: consumes the EX/MEM output bundle (WB, M, PC, zero, ALUresult, writeData, writeRegister).
- Performs the MEM-stage data-memory access over a req/ack handshake and resolves the branch (PCSrc).
- Drives the MEM/WB register. Stalls the pipeline while a multi-cycle memory access is outstanding.

Parameters:
- TIMEOUT, 16: maximum wait cycles for mem_ack (used only with the optional feature).
- AW, 32: data-memory address width.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous reset, active-high.
- WB  in  2  WB control from EX/MEM: [1] RegWrite, [0] MemtoReg.
- M  in  3  MEM control from EX/MEM: [2] Branch, [1] MemRead, [0] MemWrite.
- PC  in  32  branch target from EX/MEM.
- zero  in  1  ALU zero flag.
- ALUresult  in  32  memory address / ALU result.
- writeData  in  32  store data.
- writeRegister  in  5  destination register.
- mem_req  out  1  memory request, held until ack.
- mem_we  out  1  1 = write, 0 = read.
- mem_addr  out  AW  = ALUresult[AW-1:0].
- mem_wdata  out  32  = writeData.
- mem_rdata  in  32  read data, valid in the mem_ack cycle.
- mem_ack  in  1  one-cycle completion pulse.
- stall  out  1  freeze PC, IF/ID, ID/EX and EX/MEM.
- PCSrc  out  1  take branch.
- branch_target  out  32  = PC.
- WB_output  out  2  MEM/WB RegWrite/MemtoReg.
- readData_output  out  32  MEM/WB load data.
- ALUresult_output  out  32  MEM/WB ALU result.
- writeRegister_output  out  5  MEM/WB destination register.
- mem_err  out  1  timeout error pulse (optional feature only; tie 0 otherwise).

Behaviour:
- Reset: state IDLE; every registered output 0; mem_req 0; stall 0. A pending access is abandoned. mem_ack arriving while in reset or in IDLE is ignored.
- FSM states are IDLE and ACCESS.
- IDLE, M[1:0] == 00: pass-through. MEM/WB registers load WB, ALUresult, writeRegister at the next edge (latency 1). readData_output loads 0.
- IDLE, M[1] or M[0] set:
  - Same edge: go to ACCESS; MEM/WB loads a bubble (WB_output = 00, other fields hold).
  - stall is combinationally high in this cycle.
- ACCESS:
  - mem_req = 1; mem_we = M[0]; addr/wdata driven from the inputs. Upstream holds the inputs stable because stall is high.
  - stall = 1 in every ACCESS cycle, including the mem_ack cycle.
  - Each non-ack cycle loads a bubble into MEM/WB.
  - On mem_ack: MEM/WB loads WB, ALUresult, writeRegister, plus readData_output = mem_rdata (reads) or 0 (writes); state returns to IDLE.
  - The cycle after ack, stall = 0 and the pipeline advances.
- Minimum memory-op latency: 2 cycles with ack in the first ACCESS cycle.
- M[1:0] == 11 is illegal. The write takes priority: mem_we = 1 and readData_output = 0.
- PCSrc = M[2] & zero, combinational, forced 0 while stall = 1. Branches never touch memory.
- Reset during ACCESS: mem_req drops at the reset edge.

Optional Feature:
- Macro: MEM_TIMEOUT_EN.
- Enabled:
  - A counter of width clog2(TIMEOUT+1) is cleared on entry to ACCESS and increments each non-ack cycle.
  - When the count reaches TIMEOUT with no ack, the access aborts: return to IDLE, MEM/WB loads a bubble, mem_err pulses 1 for one cycle.
  - An ack in the same cycle as the timeout wins.
- Disabled: no counter; ACCESS waits indefinitely; mem_err is tied 0.

Decomposition:
- Shared package mips_pkg:
  - Bit-index constants M_BRANCH=2, M_MEMREAD=1, M_MEMWRITE=0, WB_REGWRITE=1, WB_MEMTOREG=0.
  - mem_state_t enum {IDLE, ACCESS}.
- One natural sub-module: mem_wb_reg, the MEM/WB pipeline register with load / bubble / reset controls. The FSM and the handshake stay in mem_stage.

Test Plan:
- ALU op: WB=10, M=000, ALUresult=0x0000_0011, writeRegister=5 -> next edge WB_output=10, ALUresult_output=0x11, writeRegister_output=5, stall=0, mem_req=0.
- Load, ack after 3 cycles: M=010, ALUresult=0x40, mem_rdata=0xDEADBEEF -> mem_req=1 for 3 cycles, stall high through the ack cycle, WB_output=00 during the wait, then readData_output=0xDEADBEEF with WB=11.
- Store, immediate ack: M=001, ALUresult=0x80, writeData=0x1F -> mem_we=1, mem_addr=0x80, mem_wdata=0x1F, stall high 2 cycles, readData_output=0.
- Branch: M=100, zero=1, PC=0x100 -> PCSrc=1, branch_target=0x100. With zero=0 -> PCSrc=0. No mem_req in either case.
- rst asserted in the 2nd ACCESS cycle, then a late mem_ack -> next edge: mem_req=0, all outputs 0, state IDLE; the late ack produces no MEM/WB load.
- MEM_TIMEOUT_EN with TIMEOUT=4, load with no ack -> exactly 4 mem_req cycles, then mem_err pulses 1 for one cycle, WB_output=00, stall drops.
